// File: rtl/regs.sv
// Register file with 31 x 32-bit storage, index 0 hardwired to zero.
// Latency: reads are combinational (zero cycles); writes commit on the rising clk edge.
// Backpressure: none; a write is accepted every cycle that L_S is high.
//
// Ports:
//   clk, rst            - single clock domain, synchronous active-high reset
//   R_addr_A / rdata_A  - read port A (ALU operand A / shift source)
//   R_addr_B / rdata_B  - read port B (ALU operand B / store data)
//   Wt_addr, Wt_data,
//   L_S                 - write port; L_S=1 writes Wt_data to Wt_addr
//   Dbg_addr / Dbg_data - debug read port
//   wr_cnt              - count of committed writes since reset (wraps)
module regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  R_addr_A,
    input  logic [4:0]  R_addr_B,
    input  logic [4:0]  Wt_addr,
    input  logic [31:0] Wt_data,
    input  logic        L_S,
    output logic [31:0] rdata_A,
    output logic [31:0] rdata_B,
    input  logic [4:0]  Dbg_addr,
    output logic [31:0] Dbg_data,
    output logic [15:0] wr_cnt
);

    // Index 0 has no storage; the array only spans 1..31.
    logic [31:0] regs_q [31:1];
    logic [15:0] wr_cnt_q;
    logic [15:0] wr_cnt_d;
    logic        wr_en;

    // Reset dominates the write enable, so a write requested in a reset
    // cycle is neither stored nor forwarded to the read ports.
    assign wr_en = L_S && !rst && (Wt_addr != 5'd0);

    assign wr_cnt_d = wr_en ? (wr_cnt_q + 16'd1) : wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= 31; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
            wr_cnt_q <= 16'h0000;
        end else begin
            if (wr_en) begin
                regs_q[Wt_addr] <= Wt_data;
            end
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Read with write-before-read forwarding. Index 0 never matches a
    // write because wr_en already excludes Wt_addr == 0.
    function automatic logic [31:0] rd_port(input logic [4:0] addr);
        logic [31:0] val;
        val = 32'h0000_0000;
        if (addr != 5'd0) begin
            if (wr_en && (addr == Wt_addr)) begin
                val = Wt_data;
            end else begin
                val = regs_q[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        rdata_A = rd_port(R_addr_A);
    end

    always_comb begin
        rdata_B = rd_port(R_addr_B);
    end

    always_comb begin
        Dbg_data = rd_port(Dbg_addr);
    end

    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regs.sv
module tb_regs;

    logic        clk;
    logic        rst;
    logic [4:0]  R_addr_A;
    logic [4:0]  R_addr_B;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;
    logic        L_S;
    logic [31:0] rdata_A;
    logic [31:0] rdata_B;
    logic [4:0]  Dbg_addr;
    logic [31:0] Dbg_data;
    logic [15:0] wr_cnt;

    int checks = 0;
    int errors = 0;

    regs dut (
        .clk      (clk),
        .rst      (rst),
        .R_addr_A (R_addr_A),
        .R_addr_B (R_addr_B),
        .Wt_addr  (Wt_addr),
        .Wt_data  (Wt_data),
        .L_S      (L_S),
        .rdata_A  (rdata_A),
        .rdata_B  (rdata_B),
        .Dbg_addr (Dbg_addr),
        .Dbg_data (Dbg_data),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unknown write enable is an illegal stimulus.
    always @(posedge clk) begin
        if ($isunknown(L_S)) begin
            errors++;
            $error("FAIL ls_unknown L_S=%b required 0 or 1", L_S);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        L_S      = 1'b0;
        Wt_addr  = 5'd0;
        Wt_data  = 32'h0;
        R_addr_A = 5'd0;
        R_addr_B = 5'd0;
        Dbg_addr = 5'd0;

        tick();
        tick();
        rst = 1'b0;
        settle();

        // Reset state: every index reads zero on all three ports.
        for (int i = 0; i < 32; i++) begin
            R_addr_A = 5'(i);
            R_addr_B = 5'(i);
            Dbg_addr = 5'(i);
            settle();
            chk($sformatf("rst_A[%0d]", i), rdata_A, 32'h0);
            chk($sformatf("rst_B[%0d]", i), rdata_B, 32'h0);
            chk($sformatf("rst_D[%0d]", i), Dbg_data, 32'h0);
        end
        chk("rst_cnt", {16'h0, wr_cnt}, 32'h0);

        // Basic write, then read on both ports.
        Wt_addr = 5'd5; Wt_data = 32'hDEAD_BEEF; L_S = 1'b1;
        tick();
        L_S = 1'b0; R_addr_A = 5'd5; R_addr_B = 5'd5; Dbg_addr = 5'd5;
        settle();
        chk("r5_A", rdata_A, 32'hDEAD_BEEF);
        chk("r5_B", rdata_B, 32'hDEAD_BEEF);
        chk("r5_D", Dbg_data, 32'hDEAD_BEEF);
        chk("r5_cnt", {16'h0, wr_cnt}, 32'd1);

        // Write to r0 is discarded and never forwarded.
        Wt_addr = 5'd0; Wt_data = 32'h1234_5678; L_S = 1'b1; R_addr_A = 5'd0;
        settle();
        chk("r0_bypass_A", rdata_A, 32'h0);
        tick();
        L_S = 1'b0;
        settle();
        chk("r0_A", rdata_A, 32'h0);
        chk("r0_cnt", {16'h0, wr_cnt}, 32'd1);

        // Idle cycle holds the counter.
        tick();
        chk("hold_cnt", {16'h0, wr_cnt}, 32'd1);

        // Same-cycle bypass on r7.
        Wt_addr = 5'd7; Wt_data = 32'h0000_0001; L_S = 1'b1;
        tick();
        L_S = 1'b0; R_addr_A = 5'd7;
        settle();
        chk("r7_pre", rdata_A, 32'h0000_0001);
        Wt_data = 32'h8000_0000; L_S = 1'b1;
        R_addr_B = 5'd3; Dbg_addr = 5'd7;
        settle();
        chk("r7_byp_A", rdata_A, 32'h8000_0000);
        chk("r7_byp_D", Dbg_data, 32'h8000_0000);
        chk("r7_byp_B_other", rdata_B, 32'h0);
        tick();
        L_S = 1'b0;
        settle();
        chk("r7_post", rdata_A, 32'h8000_0000);
        chk("r7_cnt", {16'h0, wr_cnt}, 32'd3);

        // Reset dominates a concurrent write and suppresses bypass.
        Wt_addr = 5'd31; Wt_data = 32'hFFFF_FFFF; L_S = 1'b1;
        tick();
        chk("r31_cnt", {16'h0, wr_cnt}, 32'd4);
        rst = 1'b1; Wt_data = 32'h0000_0005; R_addr_A = 5'd31;
        settle();
        chk("rst_no_byp", rdata_A, 32'hFFFF_FFFF);
        tick();
        rst = 1'b0; L_S = 1'b0;
        settle();
        chk("rst_r31", rdata_A, 32'h0);
        chk("rst_cnt2", {16'h0, wr_cnt}, 32'h0);
        Dbg_addr = 5'd5;
        settle();
        chk("rst_r5", Dbg_data, 32'h0);
        Dbg_addr = 5'd7;
        settle();
        chk("rst_r7", Dbg_data, 32'h0);

        // Counter wrap: 65535 writes reach FFFF, one more wraps to 0.
        Wt_addr = 5'd2; L_S = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            Wt_data = 32'(i);
            tick();
        end
        L_S = 1'b0;
        settle();
        chk("cnt_ffff", {16'h0, wr_cnt}, 32'h0000_FFFF);
        R_addr_A = 5'd2;
        settle();
        chk("r2_last", rdata_A, 32'd65534);
        Wt_data = 32'hA5A5_A5A5; L_S = 1'b1;
        tick();
        L_S = 1'b0;
        settle();
        chk("cnt_wrap", {16'h0, wr_cnt}, 32'h0);

        // Fill r1..r31 with their own index, read back on A and B.
        L_S = 1'b1;
        for (int i = 1; i < 32; i++) begin
            Wt_addr = 5'(i);
            Wt_data = 32'(i);
            tick();
        end
        L_S = 1'b0;
        settle();
        chk("fill_cnt", {16'h0, wr_cnt}, 32'd31);
        for (int i = 0; i < 32; i++) begin
            R_addr_A = 5'(i);
            R_addr_B = 5'(31 - i);
            Dbg_addr = 5'(i);
            settle();
            chk($sformatf("fill_A[%0d]", i), rdata_A, 32'(i));
            chk($sformatf("fill_B[%0d]", 31 - i), rdata_B, 32'(31 - i));
            chk($sformatf("fill_D[%0d]", i), Dbg_data, 32'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
